uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
//   UART transmit line stage. Accepts one byte per data_valid/busy handshake and drives tx_out
//   as a complete asynchronous frame: start bit, data bits LSB-first, optional parity, stop bit(s).
//   Bit timing comes from an internal baud counter. Sits after the byte source and drives the pad.
// PARAMETERS
//   DATA_WIDTH    8   data bits per frame (5..9)
//   CLKS_PER_BIT  16  clk cycles per serial bit (>=2)
//   STOP_BITS     1   number of stop bits (1 or 2)
//   PARITY_ODD    0   parity sense when UART_TX_PARITY_EN is defined: 0=even, 1=odd
// PORTS
//   clk         in   1           system clock, all logic on rising edge
//   rst         in   1           synchronous reset, active-high
//   data_in     in   DATA_WIDTH  byte to send, sampled at accept
//   data_valid  in   1           request to send data_in
//   busy        out  1           frame in progress; data_valid ignored while high
//   tx_out      out  1           serial line, idle high
//   tx_done     out  1           one-cycle pulse at end of last stop bit
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, tx_out=1, busy=0, tx_done=0, shift reg and counters cleared.
//   Reset mid-frame: frame abandoned, tx_out=1 next cycle, no tx_done.
//   Accept: in IDLE, data_valid=1 and busy=0 at posedge -> data_in latched; next cycle busy=1, tx_out=0.
//   data_valid while busy=1: ignored, no buffering, no error flag.
//   FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     START: tx_out=0 for CLKS_PER_BIT cycles.
//     DATA: bit i (i=0..DATA_WIDTH-1, LSB first) held CLKS_PER_BIT cycles each; bit index counter
//       width $clog2(DATA_WIDTH)+1, leaves DATA when index reaches DATA_WIDTH-1 and bit tick fires.
//     PARITY: present only with macro, see CONFIGURATION.
//     STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   Baud counter: counts 0..CLKS_PER_BIT-1, restarts to 0 on accept; bit_tick when count==CLKS_PER_BIT-1.
//   Frame length N = (1+DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, P=1 with parity else 0.
//     busy is high exactly N cycles.
//   End of frame: on the last stop-bit cycle's edge: tx_done=1 for one cycle, busy=0, state=IDLE.
//     The same cycle may accept a new data_valid, so back-to-back frames have no idle gap.
//   tx_out is registered; no combinational path from any input to tx_out, busy or tx_done.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: PARITY state after DATA, one bit time.
//     tx_out = ^data latched XOR PARITY_ODD.
//   UART_TX_PARITY_EN undefined: no PARITY state or logic; PARITY_ODD unused; DATA goes straight to STOP.
// STRUCTURE
//   Package uart_pkg: tx state enum (IDLE, START, DATA, PARITY, STOP),
//     UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0.
//   Sub-module uart_baud_counter (params CLKS_PER_BIT; ports clk, rst, restart, en, bit_tick),
//     instantiated once; FSM, shift register and bit index stay in uart_tx_framer.
// TESTING  (CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1 unless noted)
//   1. Reset then send 0xA5, no parity -> tx_out levels 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
//      busy high 40 cycles; tx_done single pulse at end.
//   2. UART_TX_PARITY_EN, PARITY_ODD=0, send 0xA5 -> parity bit 0 after data; busy 44 cycles.
//      Send 0x07 -> parity bit 1.
//   3. Back-to-back: data_valid held with 0x00 then 0xFF -> second start bit begins cycle
//      after tx_done, tx_out never idles between frames.
//   4. Assert data_valid with 0x3C at cycle 10 of a 0x55 frame -> ignored; only 0x55 sent;
//      busy timing unchanged.
//   5. rst=1 at cycle 17 of a frame -> next cycle tx_out=1, busy=0, tx_done=0;
//      fresh 0x81 sent correctly afterwards.
//   6. STOP_BITS=2, send 0xFF -> stop high 8 cycles; busy 44 cycles;
//      tx_done at end of second stop bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= (count_q == LAST_CNT) ? '0 : count_q + 1'b1;
        end
    end

    assign bit_tick = en && (count_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, stop bit(s); registered outputs.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD).
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  busy,
    output logic                  tx_out,
    output logic                  tx_done
);

    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
        $error("uart_tx_framer: DATA_WIDTH must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_framer: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
    end

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;
    logic                  tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic bit_tick;
    logic restart;
    logic end_of_frame;
    logic accept;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .en       (state_q != IDLE),
        .bit_tick (bit_tick)
    );

    // A new byte is taken either from IDLE or on the final stop-bit edge, giving gapless frames.
    assign end_of_frame = (state_q == STOP) && bit_tick && (stop_idx_q == LAST_STOP);
    assign accept       = data_valid && ((state_q == IDLE) || end_of_frame);
    assign restart      = accept;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
`else
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d    = START;
            shift_d    = data_in;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d   = (^data_in) ^ PARITY_ODD[0];
`endif
        end

        // Outputs are decoded from the next state so they can be registered without a cycle of lag.
        tx_out_d = UART_IDLE_LEVEL;
        busy_d   = (state_d != IDLE);
        case (state_d)
            START:   tx_out_d = UART_START_LEVEL;
            DATA:    tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_d = parity_d;
`endif
            default: tx_out_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_out_q   <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_out  = tx_out_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: one-stop-bit and two-stop-bit instances, CLKS_PER_BIT=4.
module tb_uart_tx_framer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam logic [31:0] A5_FRAME = 32'h54A;
`else
    localparam int P = 0;
    localparam logic [31:0] A5_FRAME = 32'h34A;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       dv0, dv1;
    logic [7:0] din0, din1;
    logic       busy0, busy1, tx0, tx1, done0, done1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut_s1 (
        .clk(clk), .rst(rst), .data_in(din0), .data_valid(dv0),
        .busy(busy0), .tx_out(tx0), .tx_done(done0)
    );

    uart_tx_framer #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)
    ) dut_s2 (
        .clk(clk), .rst(rst), .data_in(din1), .data_valid(dv1),
        .busy(busy1), .tx_out(tx1), .tx_done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin
            dv0 = v; din0 = d;
        end else begin
            dv1 = v; din1 = d;
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 0) ? tx0 : tx1;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    // Reference frame: start 0, data LSB first, even parity if enabled, then stop ones.
    function automatic logic [31:0] frame_bits(input logic [7:0] d, input int stops);
        logic [31:0] f;
        f = '0;
        f[8:1] = d;
        if (P == 1) f[9] = ^d;
        for (int s = 0; s < stops; s++) f[9 + P + s] = 1'b1;
        return f;
    endfunction

    // Called on a negedge: present a byte, advance to the first cycle of the frame.
    task automatic start_frame(input int sel, input logic [7:0] d, input logic hold);
        drive(sel, 1'b1, d);
        @(negedge clk);
        if (!hold) drive(sel, 1'b0, d);
    endtask

    // Samples nbits bit-times starting at the current negedge; optional data_valid pulse window.
    task automatic capture(input int sel, input int nbits, input int inj_s, input int inj_e,
                           input logic [7:0] inj_d, output logic [31:0] cap,
                           output int busy_cnt, output int done_cnt, output int glitches);
        logic t;
        cap = '0; busy_cnt = 0; done_cnt = 0; glitches = 0;
        for (int c = 0; c < nbits * CPB; c++) begin
            t = get_tx(sel);
            if (c % CPB == 0) cap[c / CPB] = t;
            else if (t !== cap[c / CPB]) glitches++;
            busy_cnt += int'(get_busy(sel));
            done_cnt += int'(get_done(sel));
            if (c >= inj_s && c <= inj_e) drive(sel, 1'b1, inj_d);
            else if (c == inj_e + 1) drive(sel, 1'b0, inj_d);
            @(negedge clk);
        end
    endtask

    task automatic frame_test(input int sel, input logic [7:0] d, input int stops, input string tag,
                              input int inj_s, input int inj_e, input logic [7:0] inj_d,
                              output logic [31:0] cap);
        int nbits, bc, dc, gl;
        nbits = 1 + 8 + P + stops;
        start_frame(sel, d, 1'b0);
        capture(sel, nbits, inj_s, inj_e, inj_d, cap, bc, dc, gl);
        check({tag, " bits"}, cap, frame_bits(d, stops));
        check({tag, " glitch"}, 32'(gl), 32'd0);
        check({tag, " busy_len"}, 32'(bc), 32'(nbits * CPB));
        check({tag, " early_done"}, 32'(dc), 32'd0);
        check({tag, " done_pulse"}, {29'd0, get_done(sel), get_busy(sel), get_tx(sel)}, 32'b101);
        @(negedge clk);
        check({tag, " done_clear"}, {31'd0, get_done(sel)}, 32'd0);
    endtask

    initial begin
        logic [31:0] cap;
        int bc, dc, gl, nb;

        rst = 1'b1;
        dv0 = 1'b0; din0 = '0; dv1 = 1'b0; din1 = '0;
        repeat (3) @(negedge clk);
        check("reset s1", {29'd0, done0, busy0, tx0}, 32'b001);
        check("reset s2", {29'd0, done1, busy1, tx1}, 32'b001);
        rst = 1'b0;
        @(negedge clk);

        // 1: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 (plus parity when enabled)
        frame_test(0, 8'hA5, 1, "t1 a5", -2, -2, 8'h00, cap);
        check("t1 a5 hand", cap, A5_FRAME);

`ifdef UART_TX_PARITY_EN
        // 2: even parity, 0xA5 has four ones, 0x07 has three
        frame_test(0, 8'hA5, 1, "t2 a5", -2, -2, 8'h00, cap);
        check("t2 a5 parity", {31'd0, cap[9]}, 32'd0);
        frame_test(0, 8'h07, 1, "t2 07", -2, -2, 8'h00, cap);
        check("t2 07 parity", {31'd0, cap[9]}, 32'd1);
`endif

        // 3: back-to-back, data_valid held across the whole first frame
        nb = 1 + 8 + P + 1;
        start_frame(0, 8'h00, 1'b1);
        capture(0, nb, 0, nb * CPB - 1, 8'hFF, cap, bc, dc, gl);
        check("t3 f1 bits", cap, frame_bits(8'h00, 1));
        check("t3 f1 busy_len", 32'(bc), 32'(nb * CPB));
        check("t3 seam", {29'd0, done0, busy0, tx0}, 32'b110);
        drive(0, 1'b0, 8'hFF);
        capture(0, nb, -2, -2, 8'h00, cap, bc, dc, gl);
        check("t3 f2 bits", cap, frame_bits(8'hFF, 1));
        check("t3 f2 glitch", 32'(gl), 32'd0);
        check("t3 f2 busy_len", 32'(bc), 32'(nb * CPB));
        check("t3 f2 done_cnt", 32'(dc), 32'd1);
        check("t3 f2 end", {29'd0, done0, busy0, tx0}, 32'b101);
        @(negedge clk);

        // 4: request with 0x3C at cycle 10 of a 0x55 frame is dropped
        frame_test(0, 8'h55, 1, "t4 55", 10, 10, 8'h3C, cap);
        check("t4 idle after", {30'd0, busy0, tx0}, 32'b01);

        // 5: reset at cycle 17 abandons the frame
        start_frame(0, 8'hC3, 1'b0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5 reset mid", {29'd0, done0, busy0, tx0}, 32'b001);
        rst = 1'b0;
        @(negedge clk);
        check("t5 no done", {31'd0, done0}, 32'd0);
        frame_test(0, 8'h81, 1, "t5 81", -2, -2, 8'h00, cap);

        // 6: two stop bits
        frame_test(1, 8'hFF, 2, "t6 ff", -2, -2, 8'h00, cap);
        check("t6 stop bits", {30'd0, cap[10 + P], cap[9 + P]}, 32'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
